// File: rtl/riscv_pc_unit.sv
// Program-counter unit: picks the next fetch address from a sequential, branch,
// jump or trap source; holds a redirect that arrives while fetch is stalled; and
// replaces misaligned control-flow targets with the trap vector.
module riscv_pc_unit #(
  parameter int                ADDR_W      = 32,
  parameter int                INC_BY      = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC    = ADDR_W'(32'h100),
  parameter bit                ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              pcEn,
  input  logic [1:0]        pcSel,
  input  logic [31:0]       offset,
  input  logic [31:0]       target,
  output logic [ADDR_W-1:0] pcOutput,
  output logic [ADDR_W-1:0] pcPlusInc,
  output logic              pending,
  output logic              misalignErr,
  output logic [ADDR_W-1:0] errAddr
);

  localparam logic [1:0] SEL_SEQ    = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JUMP   = 2'd2;
  localparam logic [1:0] SEL_TRAP   = 2'd3;

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [ADDR_W-1:0] w_pend_addr_next;
  logic              r_err;
  logic              w_err_next;
  logic [ADDR_W-1:0] r_err_addr;
  logic [ADDR_W-1:0] w_err_addr_next;

  logic [ADDR_W-1:0] w_offset_ext;
  logic [ADDR_W-1:0] w_target_ext;
  logic [ADDR_W-1:0] w_candidate;
  logic              w_misalign;
  logic [ADDR_W-1:0] w_resolved;

  // The offset is signed (sign-extend when the PC is wider than 32 bits);
  // the jump target is an absolute address (zero-extend when wider).
  generate
    if (ADDR_W <= 32) begin : g_narrow
      assign w_offset_ext = offset[ADDR_W-1:0];
      assign w_target_ext = target[ADDR_W-1:0];
    end else begin : g_wide
      assign w_offset_ext = {{(ADDR_W-32){offset[31]}}, offset};
      assign w_target_ext = {{(ADDR_W-32){1'b0}}, target};
    end
  endgenerate

  assign pcOutput    = r_pc;
  assign pcPlusInc   = r_pc + ADDR_W'(INC_BY);
  assign pending     = (r_state == S_PENDING);
  assign misalignErr = r_err;
  assign errAddr     = r_err_addr;

  // Candidate address from the current PC, then trap substitution if misaligned.
  always_comb begin
    w_candidate = r_pc + ADDR_W'(INC_BY);
    unique case (pcSel)
      SEL_SEQ:    w_candidate = r_pc + ADDR_W'(INC_BY);
      SEL_BRANCH: w_candidate = r_pc + w_offset_ext;
      SEL_JUMP:   w_candidate = w_target_ext & ~ADDR_W'(1);
      SEL_TRAP:   w_candidate = TRAP_VEC;
      default:    w_candidate = r_pc + ADDR_W'(INC_BY);
    endcase
    w_misalign = ALIGN_CHECK && ((pcSel == SEL_BRANCH) || (pcSel == SEL_JUMP))
                 && (w_candidate[1:0] != 2'b00);
    w_resolved = w_misalign ? TRAP_VEC : w_candidate;
  end

  // Next-state and datapath update; the error pulse defaults low every cycle.
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_pend_addr_next = r_pend_addr;
    w_err_next       = 1'b0;
    w_err_addr_next  = r_err_addr;
    unique case (r_state)
      S_IDLE: begin
        if (pcEn) begin
          w_pc_next = w_resolved;
        end else if (pcSel != SEL_SEQ) begin
          w_pend_addr_next = w_resolved;
          w_state_next     = S_PENDING;
        end
        // The error is recorded when the substitution is committed, either to
        // the PC directly or to the pending register during a stall.
        if (w_misalign && (pcEn || (pcSel != SEL_SEQ))) begin
          w_err_next      = 1'b1;
          w_err_addr_next = w_candidate;
        end
      end
      S_PENDING: begin
        // First redirect wins, except that a trap always overrides it.
        if (pcEn) begin
          w_pc_next    = (pcSel == SEL_TRAP) ? TRAP_VEC : r_pend_addr;
          w_state_next = S_IDLE;
        end else if (pcSel == SEL_TRAP) begin
          w_pend_addr_next = TRAP_VEC;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any pending redirect.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_VEC;
      r_pend_addr <= '0;
      r_err       <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_pend_addr <= w_pend_addr_next;
      r_err       <= w_err_next;
      r_err_addr  <= w_err_addr_next;
    end
  end

endmodule

// File: tb/tb_riscv_pc_unit.sv
// Bench for riscv_pc_unit: directed scenarios followed by random traffic.
// Two instances share the stimulus: index 0 checks alignment, index 1 does not.
module tb_riscv_pc_unit;

  localparam logic [31:0] TRAP = 32'h100;

  logic        clk;
  logic        resetN;
  logic        pcEn;
  logic [1:0]  pcSel;
  logic [31:0] offset;
  logic [31:0] target;

  logic [31:0] pc_a, inc_a, eaddr_a, pc_b, inc_b, eaddr_b;
  logic        pend_a, err_a, pend_b, err_b;

  riscv_pc_unit #(.ALIGN_CHECK(1'b1)) dut_a (
    .clk(clk), .resetN(resetN), .pcEn(pcEn), .pcSel(pcSel), .offset(offset),
    .target(target), .pcOutput(pc_a), .pcPlusInc(inc_a), .pending(pend_a),
    .misalignErr(err_a), .errAddr(eaddr_a));

  riscv_pc_unit #(.ALIGN_CHECK(1'b0)) dut_b (
    .clk(clk), .resetN(resetN), .pcEn(pcEn), .pcSel(pcSel), .offset(offset),
    .target(target), .pcOutput(pc_b), .pcPlusInc(inc_b), .pending(pend_b),
    .misalignErr(err_b), .errAddr(eaddr_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit verbose  = 1'b1;

  // Reference model state, one entry per instance.
  logic [31:0] m_pc    [2];
  bit          m_pend  [2];
  logic [31:0] m_paddr [2];
  bit          m_err   [2];
  logic [31:0] m_eaddr [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_pend[k] = 1'b0; m_paddr[k] = 32'h0;
      m_err[k] = 1'b0; m_eaddr[k] = 32'h0;
    end
  endtask

  // One clock edge of the specified behaviour, using the pre-edge inputs.
  task automatic model_edge(input bit en, input logic [1:0] sel,
                            input logic [31:0] off, input logic [31:0] tgt);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] cand;
      logic [31:0] res;
      bit          bad;
      m_err[k] = 1'b0;
      if (!m_pend[k]) begin
        case (sel)
          2'd0:    cand = m_pc[k] + 32'd4;
          2'd1:    cand = m_pc[k] + off;
          2'd2:    cand = {tgt[31:1], 1'b0};
          default: cand = TRAP;
        endcase
        bad = (k == 0) && (sel == 2'd1 || sel == 2'd2) && (cand % 4 != 0);
        res = bad ? TRAP : cand;
        if (en || sel != 2'd0) begin
          if (en) m_pc[k] = res;
          else begin m_pend[k] = 1'b1; m_paddr[k] = res; end
          if (bad) begin m_err[k] = 1'b1; m_eaddr[k] = cand; end
        end
      end else if (en) begin
        m_pc[k]   = (sel == 2'd3) ? TRAP : m_paddr[k];
        m_pend[k] = 1'b0;
      end else if (sel == 2'd3) begin
        m_paddr[k] = TRAP;
      end
    end
  endtask

  task automatic check_all();
    chk("a.pcOutput",    pc_a,          m_pc[0]);
    chk("a.pcPlusInc",   inc_a,         m_pc[0] + 32'd4);
    chk("a.pending",     32'(pend_a),   32'(m_pend[0]));
    chk("a.misalignErr", 32'(err_a),    32'(m_err[0]));
    chk("a.errAddr",     eaddr_a,       m_eaddr[0]);
    chk("b.pcOutput",    pc_b,          m_pc[1]);
    chk("b.pcPlusInc",   inc_b,         m_pc[1] + 32'd4);
    chk("b.pending",     32'(pend_b),   32'(m_pend[1]));
    chk("b.misalignErr", 32'(err_b),    32'(m_err[1]));
    chk("b.errAddr",     eaddr_b,       m_eaddr[1]);
  endtask

  // Apply one cycle of stimulus, advance the model, compare 1 time unit after the edge.
  task automatic step(input bit en, input logic [1:0] sel,
                      input logic [31:0] off, input logic [31:0] tgt);
    pcEn = en; pcSel = sel; offset = off; target = tgt;
    @(posedge clk);
    model_edge(en, sel, off, tgt);
    #1;
    check_all();
    if (verbose)
      $display("step en=%0d sel=%0d off=%08h tgt=%08h -> pc=%08h pend=%0d err=%0d eaddr=%08h",
               en, sel, off, tgt, pc_a, pend_a, err_a, eaddr_a);
  endtask

  // Assert reset asynchronously between edges, hold across an edge, release.
  task automatic async_reset();
    #2 resetN = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b0; pcEn = 1'b1; pcSel = 2'd0; offset = '0; target = '0;
    model_reset();
    #12;
    check_all();
    chk("reset.pc", pc_a, 32'h0);
    resetN = 1'b1;

    // Sequential run from reset.
    step(1, 0, 0, 0); chk("seq1", pc_a, 32'h4);
    step(1, 0, 0, 0); chk("seq2", pc_a, 32'h8);
    step(1, 0, 0, 0); chk("seq3", pc_a, 32'hC);

    // Negative branches, including wrap below zero and wrap past the top.
    step(1, 2, 0, 32'h40);
    step(1, 1, -32'sd8, 0); chk("br_neg", pc_a, 32'h38);
    step(1, 2, 0, 32'h4);
    step(1, 1, -32'sd8, 0); chk("br_wrap", pc_a, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);       chk("seq_wrap", pc_a, 32'h0);

    // Stalled jump with bit0 cleared.
    step(1, 2, 0, 32'h10);
    step(0, 2, 0, 32'h201); chk("stall.pc", pc_a, 32'h10); chk("stall.pend", 32'(pend_a), 1);
    step(1, 0, 0, 0);       chk("release.pc", pc_a, 32'h200); chk("release.pend", 32'(pend_a), 0);

    // Misaligned branch: trapped with checking on, taken as-is with checking off.
    step(1, 2, 0, 32'h20);
    step(1, 1, 32'd2, 0);
    chk("mis.pc", pc_a, TRAP); chk("mis.err", 32'(err_a), 1); chk("mis.eaddr", eaddr_a, 32'h22);
    chk("nochk.pc", pc_b, 32'h22); chk("nochk.err", 32'(err_b), 0);
    step(1, 0, 0, 0);       chk("mis.pulse_end", 32'(err_a), 0); chk("mis.eaddr_hold", eaddr_a, 32'h22);

    // Trap overrides an already pending jump.
    step(0, 2, 0, 32'h300);
    step(0, 1, 32'h40, 0);
    step(0, 3, 0, 0);
    step(1, 0, 0, 0);       chk("trap_prio.pc", pc_a, TRAP);

    // Reset while pending discards the redirect.
    step(0, 2, 0, 32'h300);
    async_reset();
    chk("rst_pend.pend", 32'(pend_a), 0);
    step(1, 0, 0, 0);       chk("rst_seq1", pc_a, 32'h4);
    step(1, 0, 0, 0);       chk("rst_seq2", pc_a, 32'h8);

    // Random traffic against the model.
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit          en;
      logic [1:0]  sel;
      logic [31:0] off;
      logic [31:0] tgt;
      en  = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       off = $urandom();
        1:       off = 32'($urandom_range(0, 7)) - 32'd4;
        default: off = (32'($urandom_range(0, 63)) - 32'd32) << 2;
      endcase
      tgt = ($urandom_range(0, 1) != 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      step(en, sel, off, tgt);
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_pc_unit.md
# riscv_pc_unit

Parametrised program-counter unit for the RV32I core, replacing the fixed 8-bit word-addressed counter. It generates the fetch address each cycle from one of four sources (sequential, PC-relative branch, absolute jump, trap vector), holds redirects that arrive while fetch is stalled, and detects misaligned control-flow targets. It sits between the branch/jump resolution logic and the instruction-memory address port.

## Interface
- ADDR_W, 32: width of the PC and the address outputs.
- INC_BY, 4: sequential increment (4 for byte addressing, 1 for word addressing).
- RESET_VEC, 0: PC value loaded on reset.
- TRAP_VEC, 32'h100: PC value loaded on a trap or misaligned target (truncated to ADDR_W).
- ALIGN_CHECK, 1: 1 checks that targets are 4-byte aligned; 0 disables the check.

- clk  in  1  clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- pcEn  in  1  1 = the PC may advance this cycle; 0 = stall.
- pcSel  in  2  0 sequential, 1 branch (PC + offset), 2 jump (target with bit0 cleared), 3 trap.
- offset  in  32  signed branch offset in address units.
- target  in  32  absolute jump target.
- pcOutput  out  ADDR_W  current fetch address.
- pcPlusInc  out  ADDR_W  pcOutput + INC_BY, combinational (link value).
- pending  out  1  a redirect is latched and waiting.
- misalignErr  out  1  one-cycle pulse: a misaligned target was trapped.
- errAddr  out  ADDR_W  the offending target, held until the next error.

## Operation
- Reset (asynchronous, resetN=0): pcOutput=RESET_VEC, pending=0, misalignErr=0, errAddr=0, state IDLE.
- Candidate address, computed from the current pcOutput:
  - sel 0: pcOutput + INC_BY.
  - sel 1: pcOutput + sign-extended or truncated offset.
  - sel 2: target[ADDR_W-1:0] with bit0 = 0.
  - sel 3: TRAP_VEC.
  - All sums wrap modulo 2^ADDR_W.
- A target is misaligned when ALIGN_CHECK=1, sel is 1 or 2, and candidate[1:0] != 0. A misaligned target is replaced by TRAP_VEC. In the cycle the replacement takes effect, misalignErr=1 and errAddr=the bad candidate.
- FSM state IDLE:
  - pcEn=1: pcOutput ← candidate (after the misalignment substitution).
  - pcEn=0 and sel≠0: latch the resolved candidate into the pending register (a misalignment is resolved at latch time, so the register holds TRAP_VEC and the error fields are recorded then). Go to PENDING, pending=1. pcOutput holds.
  - pcEn=0 and sel=0: hold.
- FSM state PENDING:
  - pcEn=0, sel≠3: hold. Any new redirect is ignored; the first redirect wins.
  - pcEn=0, sel=3: overwrite the pending register with TRAP_VEC. Trap has priority.
  - pcEn=1, sel=3: pcOutput ← TRAP_VEC. Go to IDLE.
  - pcEn=1, otherwise: pcOutput ← pending register. Go to IDLE, pending=0. That cycle's pcSel is discarded.
- misalignErr is high for exactly one cycle per detected error and is otherwise 0.

## Timing
- Single-cycle update: pcOutput changes on the clk edge where pcEn=1. pcPlusInc follows pcOutput combinationally.
- Stalled redirect: latched at edge N (pcEn=0). It is applied at the first later edge with pcEn=1. pending deasserts at that same edge.
- misalignErr rises at the edge that records the error and falls at the next edge.
- Reset asserted mid-PENDING: the pending redirect is discarded, and the PC restarts at RESET_VEC after release.
- Wrap-around: with ADDR_W=32, PC=32'hFFFF_FFFC and sel 0 gives 0. A branch below 0 wraps the same way.

## Test plan
- Reset and sequential run: release reset with pcEn=1, sel=0, defaults → pcOutput 0, 4, 8, 12 on successive edges; pending=0.
- Negative branch: PC=0x40, sel=1, offset=-8 → next PC 0x38. With PC=0x4, offset=-8 → 0xFFFF_FFFC (wrap).
- Stalled jump: PC=0x10, pcEn=0, sel=2, target=0x201 → PC stays 0x10, pending=1. Next edge pcEn=1, sel=0 → PC=0x200, pending=0.
- Misaligned branch: PC=0x20, sel=1, offset=2 → PC=0x100, misalignErr pulses for 1 cycle, errAddr=0x22. Same stimulus with ALIGN_CHECK=0 → PC=0x22, no error.
- Trap priority: pending jump to 0x300. Then pcEn=0, sel=3 → on the release cycle PC=0x100, not 0x300.
- Reset mid-pending: pending=1, assert resetN=0 asynchronously → pending=0 immediately. After release, PC counts 0, 4, …; the redirect is never applied.
